// File: rtl/wrf_payload_fifo.sv
// wrf_payload_fifo: circular payload buffer that releases one PAYLOAD_WORDS frame at a time to the WR fabric generator.
// Optional partial-frame flush with PAD_WORD padding is enabled by defining WRF_PAYLOAD_FLUSH_EN.
module wrf_payload_fifo #(
    parameter int          DEPTH_LOG2    = 9,
    parameter int          PAYLOAD_WORDS = 105,
    parameter int          GAP_CYCLES    = 16,
    parameter int          FLUSH_CYCLES  = 4096,
    parameter logic [15:0] PAD_WORD      = 16'h0000
) (
    input  logic                  wrf_clk,
    input  logic                  wrf_rst_n,
    input  logic [15:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wrf_send,
    input  logic                  pl_pop,
    output logic [15:0]           pl_data,
    output logic                  pl_valid,
    output logic [DEPTH_LOG2:0]   fill,
    output logic [15:0]           frames_sent
);
    localparam int FW = DEPTH_LOG2 + 1;
    localparam int WW = $clog2(PAYLOAD_WORDS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [FW-1:0] FULL    = FW'(1 << DEPTH_LOG2);
    localparam logic [FW-1:0] PW_F    = FW'(PAYLOAD_WORDS);
    localparam logic [WW-1:0] PW_W    = WW'(PAYLOAD_WORDS);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, STREAM, GAP} state_t;
    state_t state, state_nx;

    logic [15:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [WW-1:0]         words_left;
    logic [GW-1:0]         gap_cnt;
    logic                  push, pop, mv, flush_go;
    logic [15:0]           buf_word;

    assign push     = s_valid && s_ready;
    assign pop      = pl_pop && pl_valid;
    assign s_ready  = wrf_rst_n && fill != FULL;
    assign wrf_send = wrf_rst_n && state == ARM;
    assign pl_valid = wrf_rst_n && state == STREAM;
    assign pl_data  = pl_valid ? buf_word : '0;

`ifdef WRF_PAYLOAD_FLUSH_EN
    localparam int TW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);
    logic [TW-1:0] idle_cnt;
    logic [WW-1:0] data_left;
    logic          partial;
    assign partial  = fill != '0 && fill < PW_F;
    // once the reserved stored words are used up, pops return padding and leave the buffer alone
    assign mv       = pop && data_left != '0;
    assign flush_go = partial && !push && idle_cnt == FLUSH_LAST;
    assign buf_word = data_left != '0 ? mem[rd_ptr] : PAD_WORD;
    always_ff @(posedge wrf_clk)
        if (!wrf_rst_n) begin
            idle_cnt  <= '0;
            data_left <= '0;
        end else begin
            idle_cnt  <= push ? TW'(1) : (state == IDLE && partial) ? idle_cnt + TW'(1) : idle_cnt;
            data_left <= state == ARM ? (fill >= PW_F ? PW_W : WW'(fill)) : data_left - WW'(mv);
        end
`else
    logic unused_flush_cfg;
    assign unused_flush_cfg = ^{PAD_WORD, FLUSH_CYCLES};
    assign mv       = pop;
    assign flush_go = 1'b0;
    assign buf_word = mem[rd_ptr];
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (fill >= PW_F || flush_go) ? ARM : IDLE;
            ARM:     state_nx = STREAM;
            STREAM:  state_nx = (pop && words_left == WW'(1)) ? GAP : STREAM;
            GAP:     state_nx = gap_cnt == GAP_END ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wrf_clk)
        if (push) mem[wr_ptr] <= s_data;

    always_ff @(posedge wrf_clk)
        if (!wrf_rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            words_left  <= '0;
            gap_cnt     <= '0;
            frames_sent <= '0;
        end else begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr + DEPTH_LOG2'(push);
            rd_ptr      <= rd_ptr + DEPTH_LOG2'(mv);
            fill        <= fill + FW'(push) - FW'(mv);
            words_left  <= state == ARM ? PW_W : words_left - WW'(pop);
            gap_cnt     <= state == GAP ? gap_cnt + GW'(1) : '0;
            frames_sent <= frames_sent + 16'(wrf_send);
        end
endmodule

// File: tb/tb_wrf_payload_fifo.sv
// tb_wrf_payload_fifo: randomized and directed stimulus checked each cycle against a queue-and-timeline model.
// Define WRF_PAYLOAD_FLUSH_EN to build the DUT with the flush feature and run the flush scenario instead.
module tb_wrf_payload_fifo;
    localparam int DL = 9, PW = 105, GAP = 16, DEPTH = 1 << DL;
`ifdef WRF_PAYLOAD_FLUSH_EN
    localparam int FLUSH = 64;
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam int FLUSH = 4096;
    localparam bit FLUSH_EN = 1'b0;
`endif
    // non-zero padding so pad words cannot be confused with cleared output
    localparam logic [15:0] PAD = 16'hA5A5;

    logic          clk = 1'b0;
    logic          wrf_rst_n = 1'b0;
    logic [15:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          wrf_send;
    logic          pl_pop = 1'b0;
    logic [15:0]   pl_data;
    logic          pl_valid;
    logic [DL:0]   fill;
    logic [15:0]   frames_sent;

    wrf_payload_fifo #(
        .DEPTH_LOG2(DL), .PAYLOAD_WORDS(PW), .GAP_CYCLES(GAP), .FLUSH_CYCLES(FLUSH), .PAD_WORD(PAD)
    ) dut (
        .wrf_clk(clk), .wrf_rst_n(wrf_rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wrf_send(wrf_send), .pl_pop(pl_pop), .pl_data(pl_data), .pl_valid(pl_valid),
        .fill(fill), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model: stored words, and the timeline of the frame in flight
    logic [15:0] q[$];
    int cyc = 0, send_at = -1, left = 0, data_left = 0, t_free = 0, last_push = 0;
    int frames_m = 0, pops = 0, obs_send = -1, obs_pop = -1;
    bit gap_mode = 1'b0;

    task automatic step(input bit v, input logic [15:0] d, input bit p, input bit rst);
        bit ev, pushed, popped;
        int f;
        wrf_rst_n = !rst;
        s_valid = v;
        s_data = d;
        pl_pop = p;
        #1;
        f = q.size();
        ev = send_at >= 0 && cyc > send_at;
        check("s_ready", 32'(s_ready), 32'(!rst && f < DEPTH));
        if (!rst) begin
            check("wrf_send", 32'(wrf_send), 32'(cyc == send_at));
            check("pl_valid", 32'(pl_valid), 32'(ev));
            check("pl_data", 32'(pl_data), 32'(ev ? (data_left > 0 ? q[0] : PAD) : 16'h0));
            check("fill", 32'(fill), 32'(f));
            check("frames_sent", 32'(frames_sent), 32'(frames_m));
            if (wrf_send === 1'b1) begin
                // last pop, GAP_CYCLES gap cycles, one IDLE decision cycle, then the send
                if (gap_mode && obs_pop >= 0) check("frame_gap", 32'(cyc - obs_pop), 32'(GAP + 2));
                obs_send = cyc;
            end
            if (pl_valid === 1'b1 && p) obs_pop = cyc;
        end
        if (rst) begin
            q.delete();
            send_at = -1;
            left = 0;
            data_left = 0;
            frames_m = 0;
            t_free = cyc + 1;
        end else begin
            pushed = v && f < DEPTH;
            popped = p && ev;
            if (cyc == send_at) frames_m++;
            if (send_at < 0 && cyc >= t_free) begin
                if (f >= PW) begin
                    send_at = cyc + 1; left = PW; data_left = PW;
                end else if (FLUSH_EN && f > 0 && !pushed && cyc - last_push == FLUSH - 1) begin
                    send_at = cyc + 1; left = PW; data_left = f;
                end
            end
            if (popped) begin
                if (data_left > 0) begin
                    q.delete(0);
                    data_left--;
                end
                left--;
                pops++;
                if (left == 0) begin
                    send_at = -1;
                    t_free = cyc + GAP + 1;
                end
            end
            if (pushed) begin
                q.push_back(d);
                last_push = cyc;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // pop on every cycle (including IDLE/GAP, where pops must be ignored) until no frame is pending
    task automatic drain();
        int n = 0;
        while (!(send_at < 0 && q.size() < PW && cyc > t_free) && n < 3000) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int n, lp;
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_valid", 32'(pl_valid), 32'd0);
        check("rst_send", 32'(wrf_send), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);

        for (int i = 0; i < PW; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        lp = cyc - 1;
        drain();
        check("send_latency", 32'(obs_send - lp), 32'd2);
        check("frames_one", 32'(frames_sent), 32'd1);
        check("fill_empty", 32'(fill), 32'd0);

`ifndef WRF_PAYLOAD_FLUSH_EN
        begin : full_and_overlap
            int p0, stall;
            for (int i = 0; i < DEPTH + 8; i++) step(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
            check("fill_full", 32'(fill), 32'(DEPTH));
            check("ready_full", 32'(s_ready), 32'd0);
            p0 = pops;
            n = 0;
            while (pops - p0 < PW && n < 500) begin
                step(1'b0, 16'h0, 1'b1, 1'b0);
                n++;
            end
            check("fill_after_frame", 32'(fill), 32'(DEPTH - PW));
            check("ready_after_frame", 32'(s_ready), 32'd1);
            drain();

            gap_mode = 1'b1;
            obs_pop = -1;
            for (int i = 0; i < 700; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
            gap_mode = 1'b0;
            drain();

            stall = 0;
            for (int i = 0; i < 2000; i++) begin
                if (stall > 0) stall--;
                else if ($urandom_range(0, 49) == 0) stall = 10;
                step($urandom_range(0, 1) == 1, 16'($urandom), stall == 0 && $urandom_range(0, 3) != 0, 1'b0);
            end
            drain();

            for (int i = 0; i < PW; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
            p0 = pops;
            n = 0;
            while (pops - p0 < 50 && n < 500) begin
                step(1'b0, 16'h0, 1'b1, 1'b0);
                n++;
            end
            step(1'b0, 16'h0, 1'b0, 1'b1);
            check("rst_mid_valid", 32'(pl_valid), 32'd0);
            check("rst_mid_fill", 32'(fill), 32'd0);
            check("rst_mid_frames", 32'(frames_sent), 32'd0);
            for (int i = 0; i < PW; i++) step(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
            drain();
            check("frames_after_rst", 32'(frames_sent), 32'd1);
            check("fill_after_rst_frame", 32'(fill), 32'd0);
        end
`else
        for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h7000 + i), 1'b0, 1'b0);
        lp = cyc - 1;
        n = 0;
        while (obs_send < lp && n < 300) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            n++;
        end
        check("flush_latency", 32'(obs_send - lp), 32'(FLUSH));
        drain();
        check("flush_fill", 32'(fill), 32'd0);
        check("flush_frames", 32'(frames_sent), 32'd2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
